mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the EX stage: the consumer of the decoder's `MD_start`, `M_Dop`, `MD_WE` and `ALU_OUT` controls. It executes mult/multu/madd/div/divu over a fixed multi-cycle latency and owns the HI/LO registers. It serves mthi/mtlo writes and exposes HI/LO for mfhi/mflo. It raises `busy` so the hazard unit can stall any later MD-class instruction in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu/madd (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: launch operation `op` this cycle (decoder `MD_start`).
- `op` in 3: 0 mult, 1 multu, 2 madd, 3 div, 4 divu; 5–7 reserved.
- `we` in 2: 1 = mthi, 2 = mtlo, 0/3 = none (decoder `MD_WE`).
- `rs_val` in 32: forwarded rs operand (dividend or multiplicand; mthi/mtlo data).
- `rt_val` in 32: forwarded rt operand.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `busy` out 1: operation in flight.

## Operation
- States: IDLE, RUN.
- In IDLE, `start`=1 with a valid `op`:
  - latch `op`, `rs_val` and `rt_val`;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- In RUN, the counter decrements each cycle.
  - At count 1, commit the result to HI/LO and return to IDLE.
- `busy` = (state == RUN). It is registered, with no combinational path from `start`.
- Hazard rule, enforced outside this block: stall in D when the instruction is MD-class and (`start` in E or `busy`).
- Results:
  - mult: {HI,LO} = signed 64-bit rs×rt.
  - multu: {HI,LO} = unsigned 64-bit rs×rt.
  - madd: {HI,LO} = {HI,LO} + signed rs×rt, modulo 2^64, using HI/LO at commit.
  - div/divu: LO = quotient and HI = remainder, truncating toward zero; the remainder takes the dividend's sign.
- Boundaries:
  - Divide by zero (div and divu): LO = 0xFFFFFFFF, HI = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Reserved `op` with `start`: ignored, stays IDLE, HI/LO unchanged.
- `we` (IDLE only):
  - `we`=1 writes `rs_val` to HI on the clock edge.
  - `we`=2 writes `rs_val` to LO on the clock edge.
  - `we` is ignored while `busy`.
  - `we` is ignored when `start` is high in the same cycle; `start` wins.
- `start` while `busy`: ignored; the in-flight operation is unaffected.

## Timing
- `start` sampled at edge T:
  - `busy` is high in cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO take the new value at the edge ending cycle T+N.
  - `busy` is low from cycle T+N+1, and HI/LO are stable then.
- mthi/mtlo write latency: 1 edge, so `hi`/`lo` reflect the write in the next cycle.
- Reset values: `hi`=0, `lo`=0, `busy`=0, state IDLE, counter 0.
- `reset` during RUN aborts the operation at that edge. Nothing is committed and all values return to their reset values.
- Back-to-back: a new `start` is accepted in the first cycle `busy` is low.

## Configuration
- `MDU_MADD_EN` defined:
  - op 2 performs madd as specified.
- `MDU_MADD_EN` undefined:
  - op 2 is treated as reserved: ignored, no busy, HI/LO unchanged.
  - The accumulate adder is not synthesised.

## Structure
- Package `mdu_pkg` holds:
  - op encodings `MDOP_MULT`…`MDOP_DIVU`;
  - `we` encodings `MDWE_HI` and `MDWE_LO`;
  - the state enum;
  - default cycle counts.
- Sub-module `mdu_arith`: combinational 64-bit product, signed/unsigned quotient/remainder, and divide-by-zero/overflow fixups, computed from the latched operands.
- `mdu` top holds the FSM, counter, operand latches and HI/LO registers.

## Test plan
- mult: rs=0xFFFFFFFD (−3), rt=5 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu: 0xFFFFFFFF×2 → HI=0x00000001, LO=0xFFFFFFFE.
- div: −7/2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu: 7/0 → LO=0xFFFFFFFF, HI=7.
- div: 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- madd (macro on): mthi 0, mtlo 10, then madd 3×4 → HI=0, LO=22.
- madd (macro off): the same sequence leaves LO=10 and `busy` never rises.
- mtlo 0x55 asserted during busy → ignored, LO = result. `start`+`we` in the same cycle → only the operation occurs.
- `reset` in the 3rd busy cycle of a mult → next cycle HI=LO=0, `busy`=0. A subsequent mult then completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - mdu encodings, state enum, default latencies (MDU_MADD_EN selects madd support)
package mdu_pkg;

  localparam logic [2:0] MDOP_MULT  = 3'd0;
  localparam logic [2:0] MDOP_MULTU = 3'd1;
  localparam logic [2:0] MDOP_MADD  = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;

  localparam logic [1:0] MDWE_HI = 2'd1;
  localparam logic [1:0] MDWE_LO = 2'd2;

  localparam int MDU_DEF_MULT_CYCLES = 5;
  localparam int MDU_DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // An op is launchable only if it is implemented in this build; madd counts
  // as reserved when the accumulate path is left out.
  function automatic logic op_valid(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return (o <= MDOP_DIVU);
`else
    return (o <= MDOP_DIVU) && (o != MDOP_MADD);
`endif
  endfunction

  function automatic logic op_is_div(input logic [2:0] o);
    return (o == MDOP_DIV) || (o == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational product/quotient/remainder with div fixups (MDU_MADD_EN adds accumulate)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] acc,
  output logic [63:0] res
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic        [31:0] b_safe;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Zero and MIN/-1 divisors are replaced by 1: for MIN/-1 that already
  // yields the wanted quotient MIN with remainder 0, and divide-by-zero is
  // overridden below, so the divider never sees an undefined case.
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_safe   = (div_zero || div_ovf) ? 32'd1 : b;

  assign quo_s = $signed(a) / $signed(b_safe);
  assign rem_s = $signed(a) % $signed(b_safe);
  assign quo_u = a / b_safe;
  assign rem_u = a % b_safe;

`ifndef MDU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^acc;
`endif

  // Select the {HI,LO} result for the latched op
  always_comb begin
    res = 64'd0;
    case (op)
      MDOP_MULT:  res = prod_s;
      MDOP_MULTU: res = prod_u;
`ifdef MDU_MADD_EN
      MDOP_MADD:  res = acc + prod_s;
`endif
      MDOP_DIV:   res = div_zero ? {a, 32'hFFFF_FFFF} : {rem_s, quo_s};
      MDOP_DIVU:  res = div_zero ? {a, 32'hFFFF_FFFF} : {rem_u, quo_u};
      default:    res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit owning HI/LO (MDU_MADD_EN enables madd)
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [1:0]  we,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int CNT_W = 16;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      res;

  mdu_arith u_arith (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .acc ({hi_q, lo_q}),
    .res (res)
  );

  // State, counter, operand latches and HI/LO; reset aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDOP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Launch on valid start (start beats mthi/mtlo), count down, commit at count 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_valid(op)) begin
            op_d    = op;
            a_d     = rs_val;
            b_d     = rt_val;
            cnt_d   = op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = ST_RUN;
          end
        end else if (we == MDWE_HI) begin
          hi_d = rs_val;
        end else if (we == MDWE_LO) begin
          lo_d = rs_val;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = res[63:32];
          lo_d    = res[31:0];
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed scoreboard bench for mdu (MDU_MADD_EN selects madd expectations)
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  we;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb[$];
  logic [63:0] model;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .we     (we),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge with inputs idle, so consecutive calls are back-to-back.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int ncyc,
                        input logic [1:0] we_start, input bit disturb);
    logic [63:0] exp_v;
    int          cnt;
    bit          hold_ok;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    we     = we_start;
    sb.push_back(exp);
    @(negedge clk);
    start   = 1'b0;
    we      = 2'd0;
    cnt     = 0;
    hold_ok = 1'b1;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if ({hi, lo} !== model) hold_ok = 1'b0;
      if (disturb && cnt == 1) begin
        start  = 1'b1;
        op     = MDOP_DIVU;
        we     = MDWE_LO;
        rs_val = 32'h55;
      end else begin
        start = 1'b0;
        we    = 2'd0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    we    = 2'd0;
    check64({tag, "_busy_cycles"}, 64'(cnt), 64'(ncyc));
    check64({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
    exp_v = sb.pop_front();
    check64({tag, "_hilo"}, {hi, lo}, exp_v);
    model = exp_v;
  endtask

  task automatic mt(input string tag, input logic [1:0] w, input logic [31:0] v);
    we     = w;
    rs_val = v;
    @(negedge clk);
    we = 2'd0;
    if (w == MDWE_HI) model[63:32] = v;
    else              model[31:0]  = v;
    check64(tag, {hi, lo}, model);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd0;
    we     = 2'd0;
    rs_val = '0;
    rt_val = '0;
    model  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check64("rst_hilo", {hi, lo}, 64'd0);
    check64("rst_busy", {63'd0, busy}, 64'd0);

    run_op("mult_neg",  MDOP_MULT,  32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 5, 2'd0, 1'b0);
    run_op("multu_max", MDOP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 5, 2'd0, 1'b0);
    run_op("div_neg",   MDOP_DIV,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 2'd0, 1'b0);
    run_op("divu_zero", MDOP_DIVU,  32'd7,         32'd0, 64'h0000_0007_FFFF_FFFF, 10, 2'd0, 1'b0);
    run_op("div_zero",  MDOP_DIV,   32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 10, 2'd0, 1'b0);
    run_op("div_ovf",   MDOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, 2'd0, 1'b0);
    run_op("divu_big",  MDOP_DIVU,  32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC, 10, 2'd0, 1'b0);
    run_op("rsvd_op",   3'd5,       32'd1,         32'd2, model, 0, 2'd0, 1'b0);

    mt("mthi", MDWE_HI, 32'd0);
    mt("mtlo", MDWE_LO, 32'd10);
`ifdef MDU_MADD_EN
    run_op("madd",      MDOP_MADD,  32'd3, 32'd4, 64'd22, 5, 2'd0, 1'b0);
`else
    run_op("madd_off",  MDOP_MADD,  32'd3, 32'd4, model, 0, 2'd0, 1'b0);
`endif

    run_op("we_busy",   MDOP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 5, 2'd0, 1'b1);
    run_op("we_start",  MDOP_MULT,  32'd3,         32'd4, 64'd12, 5, MDWE_LO, 1'b0);

    start  = 1'b1;
    op     = MDOP_MULT;
    rs_val = 32'd9;
    rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check64("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model = 64'd0;
    check64("abort_hilo", {hi, lo}, 64'd0);
    check64("abort_busy", {63'd0, busy}, 64'd0);

    run_op("mult_after", MDOP_MULT, 32'd6, 32'd7, 64'd42, 5, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
